id_latch_rx: RTL
================

Name: id_latch_rx

Overview:
Receive end of the IF→ID bus. Captures `{inst, pc}` from the fetch stage into the IF/ID pipeline register and handles flush on taken branch, jump or ecall. Detects load-use hazards and drives `stall_flag` back to fetch. Presents registered instruction, PC, register addresses and sign-extended immediate to the decode/execute path.

Parameters:
NOP_INST, 32'h0000_0033, bubble encoding (ADD x0,x0,x0) loaded on reset/flush.
RESET_PC, 32'hffff_fffc, PC value latched with bubbles on reset/flush.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
if_id_bus_in  in  64  {inst[63:32], pc[31:0]}; inst already in architectural bit order
exe_if_jmp_bus  in  34  {jmp_flag, jmp_target[31:0], br_flag}; only the flags are used
ecall_flag  in  1  trap redirect; flushes like a jump
ex_load  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
stall_flag  out  1  hold fetch PC and this latch
id_valid  out  1  id_* outputs carry a real instruction this cycle
id_inst  out  32  latched instruction
id_pc  out  32  latched PC
rs1_addr  out  5  id_inst[19:15]
rs2_addr  out  5  id_inst[24:20]
rd_addr  out  5  id_inst[11:7]
imm  out  32  sign-extended immediate of id_inst

Behaviour:
- Reset: synchronous, active-high, on a clk edge with `rst`=1.
  - latch = {NOP_INST, RESET_PC}; state = DROP.
  - Outputs: `id_valid`=0, `stall_flag`=0, `id_inst`=32'h33, `id_pc`=32'hffff_fffc, `imm`=0.
  - Asserting `rst` mid-stall or mid-flush overrides everything.
- FSM states: DROP, RUN, STALL.
  - DROP: the first fetch word after reset is stale (PC −4). It is discarded; latch keeps the bubble. Next state RUN unconditionally.
  - RUN: evaluate flush first, then hazard (see below).
  - STALL: lasts exactly one cycle. Latch holds its content, then returns to RUN. Flush in STALL loads the bubble and goes to RUN.
- Flush: `flush = jmp_flag | br_flag | ecall_flag`.
  - Highest priority after `rst`, in any state.
  - Latch <= {NOP_INST, RESET_PC}; `id_valid` goes 0 next cycle.
  - A hazard present in the same cycle is ignored.
- Hazard: combinational on the latched instruction.
  - `hazard = ex_load & (ex_rd != 0) & ((uses_rs1 & ex_rd == rs1_addr) | (uses_rs2 & ex_rd == rs2_addr))`.
  - `uses_rs1`: opcode is not 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - `uses_rs2`: opcode is 0110011, 0100011 or 1100011.
- `stall_flag = (state == RUN) & hazard & ~flush`.
  - Combinational, so fetch sees it in the same cycle.
  - Never high two consecutive cycles.
  - Never high in DROP or during reset.
  - RUN with stall → STALL; latch holds.
- Normal load: RUN with no flush and no stall → latch <= `if_id_bus_in`.
- `id_valid` = registered valid bit AND NOT `stall_flag`.
  - The valid bit is set when the latch loads from the bus; cleared on reset, DROP or flush.
  - During a stall cycle the downstream stage sees a bubble. The same instruction is re-presented valid in the STALL-state cycle.
- Immediate decode from latched opcode, all sign-extended to 32 bits:
  - I-type (0010011, 0000011, 1100111, 1110011): inst[31:20].
  - S-type (0100011): {inst[31:25], inst[11:7]}.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.
- Latency: a bus word presented in cycle N appears on `id_*` in cycle N+1.
- The bubble instruction (x0 destination) never produces a hazard and `id_valid` is 0 for it.

Test Plan:
- Reset, then feed pc=0 inst=0x00500093 (addi x1,x0,5) in the first post-reset cycle and pc=4 in the next.
  → First word dropped; cycle after second word: `id_valid`=1, `id_pc`=4, `imm`=5.
- Latched 0x002081B3 (add x3,x1,x2) with `ex_load`=1, `ex_rd`=2.
  → `stall_flag`=1 for exactly one cycle, `id_valid`=0 that cycle, latch unchanged.
  → Next cycle `id_valid`=1, same `id_pc`.
- Same hazard with `ex_rd`=0, or latched LUI 0x123450B7 with `ex_rd`=0.
  → No stall; `imm`=0x12345000.
- `br_flag`=1 coincident with a hazard.
  → `stall_flag`=0; next cycle `id_valid`=0, `id_inst`=0x33, `id_pc`=0xffff_fffc.
- `ecall_flag`=1 while in STALL.
  → Flush wins, state RUN, bubble latched.
- B-type 0xFE000EE3 (beq x0,x0,−4) latched.
  → `imm`=0xFFFF_FFFC; `rst` pulsed mid-stream restores all reset values on the next edge.

Source files
------------

// File: rtl/id_latch_rx.sv
// IF/ID pipeline latch: captures {inst, pc} from fetch and flushes on redirect.
// Also detects load-use hazards and presents the decoded fields of the latched instruction.
module id_latch_rx #(
  parameter logic [31:0] NOP_INST = 32'h0000_0033,
  parameter logic [31:0] RESET_PC = 32'hffff_fffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_id_bus_in,
  input  logic [33:0] exe_if_jmp_bus,
  input  logic        ecall_flag,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  output logic        stall_flag,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    S_DROP  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic            r_valid;

  logic [6:0]      w_opcode;
  logic            w_flush;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_hazard;
  logic            w_stall;
  logic            w_unused_jmp;

  // Sign-extended immediate for any instruction word
  function automatic logic [XLEN-1:0] imm_decode(input logic [XLEN-1:0] inst);
    logic [XLEN-1:0] v;
    v = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        v = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        v = {inst[31:12], 12'b0};
      OP_JAL:
        v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        v = '0;
    endcase
    return v;
  endfunction

  // Only the redirect flags matter here; the jump target is consumed by fetch
  assign w_unused_jmp = ^exe_if_jmp_bus[32:1];

  assign w_opcode   = r_inst[6:0];
  assign w_flush    = exe_if_jmp_bus[33] | exe_if_jmp_bus[0] | ecall_flag;
  assign w_uses_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
  assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

  assign w_hazard = ex_load && (ex_rd != RW'(0)) &&
                    ((w_uses_rs1 && (ex_rd == r_inst[19:15])) ||
                     (w_uses_rs2 && (ex_rd == r_inst[24:20])));

  // Fetch must see the stall in the same cycle, so it stays combinational
  assign w_stall = (r_state == S_RUN) && w_hazard && !w_flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_DROP;
      r_inst  <= NOP_INST;
      r_pc    <= RESET_PC;
      r_imm   <= imm_decode(NOP_INST);
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_state <= S_RUN;
      r_inst  <= NOP_INST;
      r_pc    <= RESET_PC;
      r_imm   <= imm_decode(NOP_INST);
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_DROP: begin
          // First word after reset is stale; keep the bubble
          r_state <= S_RUN;
          r_valid <= 1'b0;
        end
        S_RUN: begin
          if (w_stall) begin
            r_state <= S_STALL;
          end else begin
            r_inst  <= if_id_bus_in[63:32];
            r_pc    <= if_id_bus_in[31:0];
            r_imm   <= imm_decode(if_id_bus_in[63:32]);
            r_valid <= 1'b1;
          end
        end
        S_STALL: begin
          r_state <= S_RUN;
        end
        default: begin
          r_state <= S_DROP;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign stall_flag = w_stall;
  assign id_valid   = r_valid && !w_stall;
  assign id_inst    = r_inst;
  assign id_pc      = r_pc;
  assign imm        = r_imm;
  assign rs1_addr   = r_inst[19:15];
  assign rs2_addr   = r_inst[24:20];
  assign rd_addr    = r_inst[11:7];

endmodule
